// File: rtl/ext_pkg.sv
// Shared types for the immediate/load extension pipeline.
// Mode codes and FIFO sizing used by the core, the pipe and the bench.
package ext_pkg;

  typedef enum logic [2:0] {
    M_SIGN     = 3'd0,
    M_ZERO     = 3'd1,
    M_HIGH     = 3'd2,
    M_SIGN_SHL = 3'd3,
    M_LB       = 3'd4,
    M_LBU      = 3'd5,
    M_LH       = 3'd6,
    M_LHU      = 3'd7
  } ext_mode_e;

  localparam int FIFO_DEPTH = 2;

  function automatic logic is_half(input ext_mode_e m);
    return (m == M_LH) || (m == M_LHU);
  endfunction

endpackage

// File: rtl/ext_if.sv
// Request/result handshake bundle for ext_pipe.
// master drives requests and consumes results; slave is the pipe.
interface ext_if #(
  parameter int DATA_W = 32
);
  import ext_pkg::*;

  logic              in_valid;
  logic              in_ready;
  ext_mode_e         in_mode;
  logic [DATA_W-1:0] in_din;
  logic [1:0]        in_boff;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid,
    output in_mode,
    output in_din,
    output in_boff,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_din,
    input  in_boff,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/ext_core.sv
// Combinational immediate / load-data extension.
// Misaligned halfword loads yield zero data with err set.
module ext_core
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SHL    = 2
) (
  input  ext_mode_e         mode,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        boff,
  output logic [DATA_W-1:0] data,
  output logic              err
);

  logic [IMM_W-1:0]  w_imm;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_bs;
  logic [DATA_W-1:0] w_bz;
  logic [DATA_W-1:0] w_hs;
  logic [DATA_W-1:0] w_hz;

  assign w_imm  = din[IMM_W-1:0];
  assign w_sext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
  assign w_zext = {{(DATA_W-IMM_W){1'b0}}, w_imm};

  always_comb begin
    w_byte = din[7:0];
    unique case (boff)
      2'd0: w_byte = din[7:0];
      2'd1: w_byte = din[15:8];
      2'd2: w_byte = din[23:16];
      2'd3: w_byte = din[31:24];
    endcase
  end

  assign w_half = boff[1] ? din[31:16] : din[15:0];

  assign w_bs = {{(DATA_W-8){w_byte[7]}}, w_byte};
  assign w_bz = {{(DATA_W-8){1'b0}}, w_byte};
  assign w_hs = {{(DATA_W-16){w_half[15]}}, w_half};
  assign w_hz = {{(DATA_W-16){1'b0}}, w_half};

  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (mode)
      M_SIGN:     data = w_sext;
      M_ZERO:     data = w_zext;
      M_HIGH:     data = w_zext << 16;
      M_SIGN_SHL: data = w_sext << SHL;
      M_LB:       data = w_bs;
      M_LBU:      data = w_bz;
      M_LH:       data = w_hs;
      M_LHU:      data = w_hz;
    endcase
    if (is_half(mode) && boff[0]) begin
      data = '0;
      err  = 1'b1;
    end
  end

endmodule

// File: rtl/ext_pipe.sv
// Extension pipe: ext_core result captured into a 2-entry FIFO
// with valid/ready on both sides and a saturating error counter.
module ext_pipe
  import ext_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SHL    = 2
) (
  input  logic       clk,
  input  logic       reset,
  ext_if.slave       bus,
  output logic [7:0] err_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } ent_t;

  ent_t          r_q [FIFO_DEPTH];
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_err_cnt;

  ent_t w_new;
  logic w_push;
  logic w_pop;
  logic w_rdy;
  logic w_vld;

  ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHL    (SHL)
  ) u_core (
    .mode (bus.in_mode),
    .din  (bus.in_din),
    .boff (bus.in_boff),
    .data (w_new.data),
    .err  (w_new.err)
  );

  // reset gates ready so nothing is taken while held in reset
  assign w_rdy  = reset && (r_cnt < DEPTH_C);
  assign w_vld  = (r_cnt != '0);
  assign w_push = bus.in_valid && w_rdy;
  assign w_pop  = w_vld && bus.out_ready;

  assign bus.in_ready  = w_rdy;
  assign bus.out_valid = w_vld;
  assign bus.out_data  = w_vld ? r_q[0].data : '0;
  assign bus.out_err   = w_vld ? r_q[0].err  : 1'b0;
  assign err_cnt       = r_err_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (w_push && w_new.err && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // payload is masked by w_vld on output, so it needs no reset
  always_ff @(posedge clk) begin
    if (w_pop) begin
      if (w_push && (r_cnt == ONE_C)) begin
        r_q[0] <= w_new;
      end else begin
        r_q[0] <= r_q[1];
      end
    end else if (w_push) begin
      if (r_cnt == '0) begin
        r_q[0] <= w_new;
      end else begin
        r_q[1] <= w_new;
      end
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// Directed self-checking bench for ext_pipe.
// Inputs change near negedge/after posedge; outputs sampled at negedge.
module tb_ext_pipe;
  import ext_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;
  int         n_vec = 0;
  int         n_err = 0;

  ext_if #(.DATA_W(32)) bus ();

  ext_pipe #(
    .DATA_W (32),
    .IMM_W  (16),
    .SHL    (2)
  ) dut (
    .clk     (clk),
    .reset   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input ext_mode_e m, input logic [31:0] d,
                       input logic [1:0] b);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_din   = d;
    bus.in_boff  = b;
  endtask

  // one request into an empty pipe, result popped immediately
  task automatic single(input string tag, input ext_mode_e m,
                        input logic [31:0] d, input logic [1:0] b,
                        input logic [31:0] exp_d, input logic exp_e);
    bus.out_ready = 1'b1;
    drive(m, d, b);
    #1;
    chk({tag, ".nocomb"}, bus.out_valid, 0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".valid"}, bus.out_valid, 1);
    chk({tag, ".data"}, bus.out_data, exp_d);
    chk({tag, ".err"}, bus.out_err, exp_e);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".drain"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = M_SIGN;
    bus.in_din    = '0;
    bus.in_boff   = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_data", bus.out_data, 0);
    chk("rst.out_err", bus.out_err, 0);
    chk("rst.err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", bus.in_ready, 1);
    @(negedge clk);

    single("sign", M_SIGN, 32'h5555_8000, 2'd0, 32'hFFFF_8000, 1'b0);
    single("zero", M_ZERO, 32'hAAAA_8000, 2'd0, 32'h0000_8000, 1'b0);
    single("high", M_HIGH, 32'hFFFF_1234, 2'd0, 32'h1234_0000, 1'b0);
    single("shl_n", M_SIGN_SHL, 32'h0000_FFFF, 2'd0, 32'hFFFF_FFFC, 1'b0);
    single("shl_p", M_SIGN_SHL, 32'h0000_4001, 2'd0, 32'h0001_0004, 1'b0);
    single("lb1", M_LB, 32'h1234_8078, 2'd1, 32'hFFFF_FF80, 1'b0);
    single("lbu1", M_LBU, 32'h1234_8078, 2'd1, 32'h0000_0080, 1'b0);
    single("lb0", M_LB, 32'h1234_8078, 2'd0, 32'h0000_0078, 1'b0);
    single("lb3", M_LB, 32'h1234_8078, 2'd3, 32'h0000_0012, 1'b0);
    single("lhu2", M_LHU, 32'h1234_8078, 2'd2, 32'h0000_1234, 1'b0);
    single("lh0", M_LH, 32'h1234_8078, 2'd0, 32'hFFFF_8078, 1'b0);
    single("lh2", M_LH, 32'h1234_8078, 2'd2, 32'h0000_1234, 1'b0);
    chk("ok.err_cnt", err_cnt, 0);

    // back-pressure: two accepted, third held until space frees
    bus.out_ready = 1'b0;
    drive(M_SIGN, 32'h0000_0001, 2'd0);
    @(posedge clk);
    #1 drive(M_ZERO, 32'h0000_FFFF, 2'd0);
    @(posedge clk);
    #1 drive(M_HIGH, 32'h0000_00AB, 2'd0);
    @(negedge clk);
    chk("bp.full_rdy", bus.in_ready, 0);
    chk("bp.valid", bus.out_valid, 1);
    chk("bp.head", bus.out_data, 32'h0000_0001);
    @(posedge clk);
    @(negedge clk);
    chk("bp.still_full", bus.in_ready, 0);
    chk("bp.hold", bus.out_data, 32'h0000_0001);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp.second", bus.out_data, 32'h0000_FFFF);
    chk("bp.rdy_again", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp.third", bus.out_data, 32'h00AB_0000);
    chk("bp.third_v", bus.out_valid, 1);
    @(posedge clk);
    @(negedge clk);
    chk("bp.empty", bus.out_valid, 0);

    // streaming at count 1: one result per cycle
    bus.out_ready = 1'b1;
    drive(M_ZERO, 32'h0000_0100, 2'd0);
    @(posedge clk);
    for (int i = 1; i <= 5; i++) begin
      #1 drive(M_ZERO, 32'h0000_0100 + 32'(i), 2'd0);
      @(negedge clk);
      chk("st.data", bus.out_data, 32'h0000_0100 + 32'(i - 1));
      chk("st.rdy", bus.in_ready, 1);
      @(posedge clk);
    end
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("st.last", bus.out_data, 32'h0000_0105);
    @(posedge clk);
    @(negedge clk);
    chk("st.empty", bus.out_valid, 0);

    // misaligned halfword loads and error counter saturation
    single("lh_mis", M_LH, 32'h1234_8078, 2'd1, 32'h0, 1'b1);
    chk("mis.cnt1", err_cnt, 1);
    single("lhu_mis", M_LHU, 32'h1234_8078, 2'd3, 32'h0, 1'b1);
    chk("mis.cnt2", err_cnt, 2);
    bus.out_ready = 1'b1;
    drive(M_LH, 32'h0, 2'd1);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 251) chk("sat.254", err_cnt, 254);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("sat.255", err_cnt, 255);
    chk("sat.err", bus.out_err, 1);
    @(posedge clk);
    @(negedge clk);
    chk("sat.empty", bus.out_valid, 0);

    // reset mid-cycle with a full FIFO
    bus.out_ready = 1'b0;
    drive(M_SIGN, 32'h0000_7FFF, 2'd0);
    @(posedge clk);
    #1 drive(M_SIGN, 32'h0000_8001, 2'd0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rq.full", bus.in_ready, 0);
    chk("rq.head", bus.out_data, 32'h0000_7FFF);
    #2 rst_n = 1'b0;
    #1;
    chk("rq.valid0", bus.out_valid, 0);
    chk("rq.data0", bus.out_data, 0);
    chk("rq.err0", bus.out_err, 0);
    chk("rq.cnt0", err_cnt, 0);
    chk("rq.rdy0", bus.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rq.rdy1", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rq.nostale", bus.out_valid, 0);
    end
    single("post", M_LBU, 32'h1234_8078, 2'd3, 32'h0000_0012, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
